// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the CPU/DMA memory arbiter.
//                Arbitration state encoding, the data/address word width and
//                the helper that sizes the starvation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Width of every address and data word moved through the arbiter.
  localparam int unsigned DATA_W = 32;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_t;

  // Bits needed to count from 0 up to limit inclusive (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : arb_starve_cnt
//  Description : Saturating count of consecutive CPU grants that were made
//                while DMA was waiting. starve is high once the count has
//                reached STARVE_LIMIT (so a limit of 0 is always saturated).
//                Only instantiated when MEM_ARB_STARVE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  localparam int unsigned      CNT_W   = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over increment; increment stops at the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT_C)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starve = (count_q == LIMIT_C);

endmodule : arb_starve_cnt
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (CPU pipeline / DMA) arbiter in front of a
//                single-ported memory with a ready handshake. CPU wins ties;
//                with MEM_ARB_STARVE_EN defined, DMA is forced through after
//                STARVE_LIMIT consecutive CPU grants made while it waited.
//                Without the macro the CPU has strict priority and
//                STARVE_LIMIT has no effect.
//                Every transfer is followed by one idle cycle.
//  Config      : `define MEM_ARB_STARVE_EN to enable the starvation guard.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // CPU pipeline port
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // DMA / host port
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  // Memory port
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state_q;
  arb_state_t        state_d;

  // Transfer captured at grant time; requester inputs are ignored afterwards.
  logic              wr_q;
  logic              wr_d;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;

  // Last read data returned to each requester.
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q;
  logic [DATA_W-1:0] dma_rdata_d;

  logic              grant_cpu;
  logic              grant_dma;
  logic              cpu_done;
  logic              dma_done;
  logic              starve;

  // --------------------------------------------------------------------------
  // Starvation guard
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_EN
  logic starve_sat;
  logic cnt_inc;
  logic cnt_clr;

  // Count CPU wins that happen while DMA is asking; forget the history
  // whenever DMA is served or stops asking while the bus is free.
  assign cnt_inc = grant_cpu & dma_req;
  assign cnt_clr = grant_dma | ((state_q == ARB_IDLE) & ~dma_req);

  arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .starve (starve_sat)
  );

  assign starve = starve_sat & dma_req;
`else
  // Grant strobes and the limit only feed the guard; tie them off here.
  logic unused_starve_inputs;
  assign unused_starve_inputs = (STARVE_LIMIT == 0) ^ grant_cpu ^ grant_dma;
  assign starve = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Arbitration FSM
  // --------------------------------------------------------------------------

  // Next state and grant capture: decide only in IDLE, finish on mem_ready.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (starve || (dma_req && !cpu_req)) begin
          grant_dma = 1'b1;
          state_d   = ARB_DMA;
          wr_d      = dma_wr;
          addr_d    = dma_addr;
          wdata_d   = dma_wdata;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
          state_d   = ARB_CPU;
          wr_d      = cpu_wr;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
        end
      end
      ARB_CPU, ARB_DMA: begin
        // A dropped request does not abort: only mem_ready ends the cycle.
        if (mem_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and captured transfer registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Completion and read-data return
  // --------------------------------------------------------------------------

  // Completion strobes and read-data next values (loads only update data).
  always_comb begin
    cpu_done    = (state_q == ARB_CPU) && mem_ready;
    dma_done    = (state_q == ARB_DMA) && mem_ready;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    if (cpu_done && !wr_q) begin
      cpu_rdata_d = mem_rdata;
    end
    if (dma_done && !wr_q) begin
      dma_rdata_d = mem_rdata;
    end
  end

  // Read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------

  // Memory strobes come straight from the state register so that an
  // asynchronous reset removes them without waiting for a clock edge.
  assign mem_en    = (state_q != ARB_IDLE);
  assign mem_wr    = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // The completing load's data is visible in the completion cycle itself and
  // is held by the register afterwards.
  assign cpu_rdata = cpu_rdata_d;
  assign dma_rdata = dma_rdata_d;

  assign cpu_stall = cpu_req & ~cpu_done;
  assign dma_ack   = dma_done;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A transaction-level
//                owner/queue model predicts every output each cycle, and
//                directed scenarios pin key cycles with literal values.
//                Honours MEM_ARB_STARVE_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wr, dma_req, dma_wr, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dma_ack, mem_en, mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_wr    (dma_wr),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = bus free, 1 = CPU transfer in flight, 2 = DMA transfer in flight
  int          m_owner;
  int          m_cnt;
  logic        m_wr;
  logic [31:0] m_addr, m_wdata, m_cpu_rd, m_dma_rd;
  logic        m_starve;

  assign m_starve = STARVE_EN && dma_req && (m_cnt >= LIMIT);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  <= 0;
      m_cnt    <= 0;
      m_wr     <= 1'b0;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
      m_cpu_rd <= 32'h0;
      m_dma_rd <= 32'h0;
    end else if (m_owner != 0) begin
      if (mem_ready) begin
        if (!m_wr && m_owner == 1) m_cpu_rd <= mem_rdata;
        if (!m_wr && m_owner == 2) m_dma_rd <= mem_rdata;
        m_owner <= 0;
      end
    end else begin
      if (m_starve || (dma_req && !cpu_req)) begin
        m_owner <= 2; m_wr <= dma_wr; m_addr <= dma_addr; m_wdata <= dma_wdata;
        m_cnt   <= 0;
      end else if (cpu_req) begin
        m_owner <= 1; m_wr <= cpu_wr; m_addr <= cpu_addr; m_wdata <= cpu_wdata;
        if (dma_req && m_cnt < LIMIT) m_cnt <= m_cnt + 1;
      end
      if (!dma_req) m_cnt <= 0;
    end
  end

  logic        e_busy, e_cpu_done, e_dma_done;
  logic [31:0] e_cpu_rd, e_dma_rd;
  assign e_busy     = (m_owner != 0);
  assign e_cpu_done = (m_owner == 1) && mem_ready;
  assign e_dma_done = (m_owner == 2) && mem_ready;
  assign e_cpu_rd   = (e_cpu_done && !m_wr) ? mem_rdata : m_cpu_rd;
  assign e_dma_rd   = (e_dma_done && !m_wr) ? mem_rdata : m_dma_rd;

  // Per-cycle comparison against the model, half a cycle after the edge.
  always @(negedge clk) begin
    chk("mdl_mem_en",    32'(mem_en),    32'(e_busy));
    chk("mdl_mem_wr",    32'(mem_wr),    32'(e_busy && m_wr));
    chk("mdl_cpu_stall", 32'(cpu_stall), 32'(cpu_req && !e_cpu_done));
    chk("mdl_dma_ack",   32'(dma_ack),   32'(e_dma_done));
    chk("mdl_cpu_rdata", cpu_rdata, e_cpu_rd);
    chk("mdl_dma_rdata", dma_rdata, e_dma_rd);
    if (e_busy || !rst_n) begin
      chk("mdl_mem_addr",  mem_addr,  m_addr);
      chk("mdl_mem_wdata", mem_wdata, m_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int       stall_n, acks, ncomp;
  logic [9:0] seq;

  initial begin
    rst_n = 1'b1;
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    #1 rst_n = 1'b0;
    repeat (2) step();

    // Reset values
    @(negedge clk);
    chk("rst_mem_en",    32'(mem_en),  32'd0);
    chk("rst_mem_wr",    32'(mem_wr),  32'd0);
    chk("rst_dma_ack",   32'(dma_ack), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    chk("rst_mem_addr",  mem_addr,  32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    step();
    rst_n = 1'b1;

    // CPU load, ready three cycles after mem_en
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    stall_n = 0;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 4);
      @(negedge clk);
      if (cpu_stall) stall_n++;
      if (c == 1) chk("r20_mem_addr", mem_addr, 32'h10);
      if (c == 4) begin
        chk("r20_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("r20_stall_low", 32'(cpu_stall), 32'd0);
      end
      step();
    end
    cpu_req = 0; mem_ready = 0; mem_rdata = 32'h0BADF00D;
    chk("r20_stall_cycles", 32'(stall_n), 32'd4);
    @(negedge clk);
    chk("r20_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    step();

    // Simultaneous requests: CPU first, bubble, then DMA
    cpu_req = 1; cpu_addr = 32'h30; dma_req = 1; dma_wr = 0; dma_addr = 32'h40;
    mem_ready = 1; mem_rdata = 32'h12345678; acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) cpu_req = 0;
      if (c == 4) dma_req = 0;
      @(negedge clk);
      if (dma_ack) acks++;
      if (c == 1) chk("r21_cpu_first", mem_addr, 32'h30);
      if (c == 2) chk("r21_bubble", 32'(mem_en), 32'd0);
      if (c == 3) begin
        chk("r21_dma_addr", mem_addr, 32'h40);
        chk("r21_dma_ack", 32'(dma_ack), 32'd1);
        chk("r21_dma_rdata", dma_rdata, 32'h12345678);
      end
      step();
    end
    chk("r21_ack_count", 32'(acks), 32'd1);

    // DMA write, request withdrawn after the grant
    dma_req = 1; dma_wr = 1; dma_addr = 32'h20; dma_wdata = 32'h55AA;
    mem_ready = 0; mem_rdata = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) dma_req = 0;
      mem_ready = (c == 3);
      @(negedge clk);
      if (c == 3) begin
        chk("r23_mem_wr", 32'(mem_wr), 32'd1);
        chk("r23_mem_addr", mem_addr, 32'h20);
        chk("r23_mem_wdata", mem_wdata, 32'h55AA);
        chk("r23_ack", 32'(dma_ack), 32'd1);
        chk("r23_rdata_kept", dma_rdata, 32'h12345678);
      end
      if (c == 4) chk("r23_ack_single", 32'(dma_ack), 32'd0);
      step();
    end
    dma_wr = 0;

    // Reset in the middle of a CPU transfer
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h44; mem_ready = 0; mem_rdata = 32'hCAFEF00D;
    step();
    @(negedge clk);
    chk("r24_busy", 32'(mem_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r24_async_drop", 32'(mem_en), 32'd0);
    chk("r24_no_ack", 32'(dma_ack), 32'd0);
    chk("r24_rdata_clr", cpu_rdata, 32'h0);
    step();
    rst_n = 1'b1; mem_ready = 1;
    @(negedge clk);
    chk("r24_idle_after", 32'(mem_en), 32'd0);
    step();
    @(negedge clk);
    chk("r24_regrant_addr", mem_addr, 32'h44);
    chk("r24_regrant_rdata", cpu_rdata, 32'hCAFEF00D);
    step();
    cpu_req = 0; mem_ready = 0;

    // Sustained contention: starvation guard pattern
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cpu_req = 1; dma_req = 1; cpu_wr = 0; dma_wr = 0; mem_ready = 1;
    seq = '0; ncomp = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cpu_req && !cpu_stall) ncomp++;
      if (dma_ack) begin
        if (ncomp < 10) seq[ncomp] = 1'b1;
        ncomp++;
      end
      step();
    end
    cpu_req = 0; dma_req = 0; mem_ready = 0;
    chk("r22_completions", 32'(ncomp), 32'd10);
    chk("r22_pattern", 32'(seq), STARVE_EN ? 32'h210 : 32'h0);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
